// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_XOR = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_MUL = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// Only the low WIDTH bits are kept, which equal the low bits of the signed product.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mult_q, mult_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_step;
    logic [SHW:0]     cnt_q, cnt_d;

    // Next accumulator value and shift-register/counter updates.
    always_comb begin
        acc_step = mult_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d  = mcand_q;
        mult_d   = mult_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d = a;
            mult_d  = b;
            acc_d   = '0;
            cnt_d   = (SHW + 1)'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_d   = acc_step;
            mcand_d = mcand_q << 1;
            mult_d  = mult_q >> 1;
            cnt_d   = cnt_q - 1'b1;
        end
    end

    // The last iteration's sum is presented combinationally so the top can register it.
    assign done    = (cnt_q == (SHW + 1)'(1));
    assign product = acc_step;

    // Iteration state; reset aborts any product in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            mult_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU: single-cycle ops plus an optional iterative multiply.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MUL_EN = 1'b1,
    parameter int unsigned SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_ip_1,
    input  logic [WIDTH-1:0] alu_ip_2,
    input  logic [2:0]       alu_op,
    input  logic             beq_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             overflow,
    output logic             beq_taken,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             beq_taken_q, beq_taken_d;
    logic             beq_q, beq_d;

    logic             accept, is_mul, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] b_eff, add_res, res;
    logic             add_ov, res_ov;

    assign in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = MUL_EN && (alu_op == ALU_MUL);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (alu_ip_1),
        .b       (alu_ip_2),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath; SUB reuses the adder with a negated B.
    always_comb begin
        b_eff   = (alu_op == ALU_SUB) ? -alu_ip_2 : alu_ip_2;
        add_res = alu_ip_1 + b_eff;
        add_ov  = (alu_ip_1[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (add_res[WIDTH-1] != alu_ip_1[WIDTH-1]);
        res     = '0;
        res_ov  = 1'b0;
        unique case (alu_op)
            ALU_ADD, ALU_SUB: begin
                res    = add_res;
                res_ov = add_ov;
            end
            ALU_AND: res = alu_ip_1 & alu_ip_2;
            ALU_XOR: res = alu_ip_1 ^ alu_ip_2;
            ALU_OR:  res = alu_ip_1 | alu_ip_2;
            ALU_SLT: res = {{(WIDTH - 1){1'b0}}, ($signed(alu_ip_1) < $signed(alu_ip_2))};
            ALU_SLL: res = alu_ip_1 << alu_ip_2[SHW-1:0];
            ALU_MUL: res = '0;  // illegal when the multiplier is not built
            default: res = '0;
        endcase
    end

    // Next state and output register: accept beats completion beats drain.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        alu_out_d   = alu_out_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        beq_taken_d = beq_taken_q;
        beq_d       = beq_q;
        if (accept) begin
            beq_d = beq_inst;
            if (is_mul) begin
                state_d     = ST_MUL;
                out_valid_d = 1'b0;
            end else begin
                alu_out_d   = res;
                zero_d      = (res == '0);
                overflow_d  = res_ov;
                beq_taken_d = beq_inst && (res == '0);
                out_valid_d = 1'b1;
            end
        end else if ((state_q == ST_MUL) && mul_done) begin
            state_d     = ST_IDLE;
            alu_out_d   = mul_product;
            zero_d      = (mul_product == '0);
            overflow_d  = 1'b0;
            beq_taken_d = beq_q && (mul_product == '0);
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            beq_taken_q <= 1'b0;
            beq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            beq_taken_q <= beq_taken_d;
            beq_q       <= beq_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign beq_taken = beq_taken_q;
    assign busy      = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a result scoreboard fed at acceptance.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk, rst_n;
    logic         in_valid, in_ready, beq_inst;
    logic         out_valid, out_ready;
    logic         zero, overflow, beq_taken, busy;
    logic [W-1:0] alu_ip_1, alu_ip_2, alu_out;
    logic [2:0]   alu_op;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        bt;
    } exp_t;

    exp_t scb[$];

    logic [2:0]  t_op [5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [31:0] t_a  [5] = '{32'hF0F01234, 32'hF0F01234, 32'hF0F01234, 32'hFFFFFFFF, 32'd1};
    logic [31:0] t_b  [5] = '{32'h0FF04321, 32'h0FF04321, 32'h0FF04321, 32'd1, 32'd35};
    logic [31:0] t_e  [5] = '{32'h00F00220, 32'hFF005115, 32'hFFF05335, 32'd1, 32'd8};

    alu_seq #(
        .WIDTH  (W),
        .MUL_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ip_1  (alu_ip_1),
        .alu_ip_2  (alu_ip_2),
        .alu_op    (alu_op),
        .beq_inst  (beq_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .zero      (zero),
        .overflow  (overflow),
        .beq_taken (beq_taken),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, required finish");
        $fatal(1);
    end

    // Reference model built from wide signed arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic beq);
        exp_t   e;
        longint sa   = longint'($signed(a));
        longint sbv  = longint'($signed(b));
        longint maxv = 64'sd2147483647;
        longint minv = -64'sd2147483648;
        longint s;
        logic [31:0] r;
        logic [4:0]  sh;
        logic        ov;
        ov = 1'b0;
        sh = b[4:0];
        case (op)
            3'd0: begin r = a + b; s = sa + sbv; ov = (s > maxv) || (s < minv); end
            3'd1: begin r = a - b; s = sa - sbv; ov = (s > maxv) || (s < minv); end
            3'd2: r = a & b;
            3'd3: r = a ^ b;
            3'd4: r = a | b;
            3'd5: r = (sa < sbv) ? 32'd1 : 32'd0;
            3'd6: r = a << sh;
            default: r = a * b;
        endcase
        e.res = r;
        e.z   = (r == 32'd0);
        e.ov  = ov;
        e.bt  = beq && (r == 32'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic beq);
        in_valid = 1'b1;
        alu_op   = op;
        alu_ip_1 = a;
        alu_ip_2 = b;
        beq_inst = beq;
    endtask

    // Observe handshakes just before the edge, then advance one cycle.
    task automatic tick();
        exp_t e;
        #1;
        if (in_valid && in_ready) scb.push_back(model(alu_op, alu_ip_1, alu_ip_2, beq_inst));
        if (out_valid && out_ready) begin
            chk("scb_has_entry", 32'(scb.size() > 0), 32'd1);
            if (scb.size() > 0) begin
                e = scb.pop_front();
                chk("sb_result", alu_out, e.res);
                chk("sb_zero", 32'(zero), 32'(e.z));
                chk("sb_overflow", 32'(overflow), 32'(e.ov));
                chk("sb_beq_taken", 32'(beq_taken), 32'(e.bt));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t dropped;
        logic saw_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_op    = 3'd0;
        alu_ip_1  = '0;
        alu_ip_2  = '0;
        beq_inst  = 1'b0;

        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_out", alu_out, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_beq_taken", 32'(beq_taken), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // ADD overflow into the sign bit, single-cycle valid pulse.
        drive(3'd0, 32'h7FFFFFFF, 32'd1, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("add_ov_out", alu_out, 32'h80000000);
        chk("add_ov_flag", 32'(overflow), 32'd1);
        chk("add_ov_zero", 32'(zero), 32'd0);
        chk("add_ov_valid", 32'(out_valid), 32'd1);
        tick();
        chk("add_ov_valid_drop", 32'(out_valid), 32'd0);

        // Branch compare: equal then unequal, back to back.
        drive(3'd1, 32'd5, 32'd5, 1'b1);
        tick();
        chk("beq_eq_out", alu_out, 32'd0);
        chk("beq_eq_zero", 32'(zero), 32'd1);
        chk("beq_eq_taken", 32'(beq_taken), 32'd1);
        drive(3'd1, 32'd5, 32'd4, 1'b1);
        tick();
        chk("beq_ne_out", alu_out, 32'd1);
        chk("beq_ne_taken", 32'(beq_taken), 32'd0);

        // Logic, SLT and SLL at one result per cycle.
        for (int i = 0; i < 5; i++) begin
            drive(t_op[i], t_a[i], t_b[i], 1'b0);
            tick();
            chk("b2b_out", alu_out, t_e[i]);
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();

        // MUL -3 x 7 with in_valid held high throughout.
        drive(3'd7, 32'hFFFFFFFD, 32'd7, 1'b0);
        tick();
        for (int i = 0; i < 32; i++) begin
            chk("mul_busy", 32'(busy), 32'd1);
            chk("mul_in_ready", 32'(in_ready), 32'd0);
            chk("mul_no_valid", 32'(out_valid), 32'd0);
            tick();
        end
        chk("mul_valid", 32'(out_valid), 32'd1);
        chk("mul_out", alu_out, 32'hFFFFFFEB);
        chk("mul_busy_done", 32'(busy), 32'd0);
        chk("mul_overflow", 32'(overflow), 32'd0);
        in_valid = 1'b0;
        tick();

        // Backpressure holds the result; the pending bundle enters on the transfer edge.
        out_ready = 1'b0;
        drive(3'd0, 32'd2, 32'd3, 1'b0);
        tick();
        drive(3'd0, 32'd10, 32'd20, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("hold_out", alu_out, 32'd5);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("pending_out", alu_out, 32'd30);
        chk("pending_valid", 32'(out_valid), 32'd1);
        tick();

        // Reset in the middle of a multiply.
        drive(3'd7, 32'd100, 32'd3, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out", alu_out, 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        if (scb.size() > 0) dropped = scb.pop_back();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        chk("abort_no_valid", 32'(saw_valid), 32'd0);
        drive(3'd0, 32'd1, 32'd1, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("after_abort_add", alu_out, 32'd2);
        chk("after_abort_valid", 32'(out_valid), 32'd1);
        tick();
        chk("scb_empty", 32'(scb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Operands are accepted through a valid/ready input channel.
- The result, flags and branch decision are registered and held on a valid/ready output channel.
- Adds OR, SLT and SLL as single-cycle ops, plus an iterative multi-cycle multiply. Sits in EX between operand muxes and the EX/MEM register; the stall logic uses busy/in_ready.

Parameters:
- WIDTH, 32, datapath width in bits; must be >= 4 and a power of 2.
- MUL_EN, 1, 1 = MUL implemented; 0 = MUL treated as illegal (result 0, single-cycle).
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand bundle valid.
- in_ready, output, 1, block can accept a bundle this cycle.
- alu_ip_1, input, WIDTH, operand A (signed).
- alu_ip_2, input, WIDTH, operand B (signed).
- alu_op, input, 3, 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 OR, 5 SLT, 6 SLL, 7 MUL.
- beq_inst, input, 1, the op is a branch compare.
- out_valid, output, 1, result bundle valid.
- out_ready, input, 1, consumer takes the result.
- alu_out, output, WIDTH, result.
- zero, output, 1, alu_out == 0.
- overflow, output, 1, signed overflow on ADD/SUB; 0 for all other ops.
- beq_taken, output, 1, beq_inst captured AND zero.
- busy, output, 1, multiply in progress.

Behaviour:
- Clock/reset:
  - Single clock clk.
  - rst_n is asynchronous and active-low.
  - Reset values: state IDLE, out_valid 0, alu_out 0, zero 0, overflow 0, beq_taken 0, busy 0, in_ready 0 while rst_n low.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - A bundle is accepted on a rising edge where in_valid && in_ready.
  - An output transfer occurs on an edge where out_valid && out_ready.
  - When out_valid=1 and out_ready=0, all outputs are held bit-stable.
- Single-cycle ops (0-6), accepted at edge k:
  - Result, flags and out_valid=1 are registered at edge k; visible after k.
  - Back-to-back acceptance is allowed when out_ready=1: throughput 1 per cycle.
- ALU arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - Overflow = sign(A)==sign(B') && sign(result)!=sign(A), where B' is B for ADD and -B for SUB.
  - SLT is signed: result is 1 or 0.
  - SLL: A << B[SHW-1:0]; upper bits of B are ignored.
- MUL (MUL_EN=1), accepted at edge k:
  - state IDLE->MUL; busy=1 from k.
  - Shift-add iteration runs one bit per cycle for WIDTH cycles.
  - At edge k+WIDTH: low WIDTH bits of the signed product are registered, out_valid=1, state->IDLE, busy=0.
  - Flags: overflow=0; zero per result.
- Output clearing: out_valid drops after the transfer edge unless a new bundle is accepted on that same edge; in that case the new result replaces the old one.
- Branch:
  - beq_inst is captured with the bundle.
  - beq_taken = captured beq_inst && zero, registered with the result.
  - beq_taken = 0 when beq_inst was 0.
- Illegal ops: op 7 with MUL_EN=0 gives result 0, zero=1, single-cycle.
- Reset: reset mid-MUL aborts immediately; the partial product is discarded and no out_valid is produced.
- Inputs are sampled only at acceptance. Operand changes during MUL have no effect.

Decomposition:
- Package alu_pkg holds:
  - op codes ALU_ADD..ALU_MUL (3-bit localparams);
  - state encoding ST_IDLE=1'b0, ST_MUL=1'b1.
- One sub-module: alu_mul_iter (WIDTH):
  - inputs start, a, b;
  - outputs done, product[WIDTH-1:0];
  - contains the multiplicand/multiplier shift registers and a SHW+1-bit down-counter.
- Top level holds the op decode, flag logic, output register and handshake.

Test Plan (WIDTH=32):
1. Reset release, then ADD 0x7FFFFFFF+1, out_ready=1 -> after 1 edge: alu_out=0x80000000, overflow=1, zero=0, out_valid=1 for exactly 1 cycle.
2. SUB 5-5 with beq_inst=1 -> alu_out=0, zero=1, beq_taken=1. Then SUB 5-4 with beq_inst=1 -> beq_taken=0.
3. Back-to-back AND/XOR/OR/SLT(-1,1)/SLL(1,35) with out_ready=1 -> one result per cycle: SLT=1, SLL=0x00000008; in_ready stays 1.
4. MUL -3 x 7 -> busy=1 and in_ready=0 for 32 cycles. out_valid at edge k+32 with alu_out=0xFFFFFFEB (-21); in_valid held high does not cause a second acceptance.
5. ADD 2+3 with out_ready=0 for 4 cycles -> alu_out=5 and out_valid held stable, in_ready=0. Then out_ready=1 -> transfer, and the pending input is accepted on the same edge.
6. rst_n pulsed low at cycle 10 of a MUL -> outputs zero immediately (async), no out_valid after release. A following ADD 1+1 -> 2 after 1 edge.
